log2_approx: RTL

LOG2_APPROX -- requirements
Module: log2_approx

---
 rtl/log2_pkg.sv | 13 +
 rtl/log2_approx.sv | 87 ++++++++
 2 files changed

// File: rtl/log2_pkg.sv
// Shared types and default sizing for the iterative Mitchell log2 approximator.
package log2_pkg;

  localparam int LOG2_IN_BIT   = 32;
  localparam int LOG2_FRAC_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } log2_state_t;

endpackage

// File: rtl/log2_approx.sv
// Mitchell log2 approximation: shifts the operand left one bit per cycle until
// the leading one reaches the MSB, then takes the bits below it as the fraction.
module log2_approx
  import log2_pkg::*;
#(
  parameter int  IN_BIT   = LOG2_IN_BIT,
  parameter int  FRAC_BIT = LOG2_FRAC_BIT,
  localparam int LZ_W     = $clog2(IN_BIT),
  localparam int OUT_W    = LZ_W + FRAC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_BIT-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_zero
);

  log2_state_t       state_reg, state_next;
  logic [IN_BIT-1:0] shift_reg, shift_next;
  logic [LZ_W-1:0]   lz_reg, lz_next;
  logic [OUT_W-1:0]  data_reg, data_next;
  logic              zero_reg, zero_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      lz_reg    <= '0;
      data_reg  <= '0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      lz_reg    <= lz_next;
      data_reg  <= data_next;
      zero_reg  <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    lz_next    = lz_reg;
    data_next  = data_reg;
    zero_next  = zero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (in_data == '0) begin
            data_next  = '0;
            zero_next  = 1'b1;
            state_next = DONE;
          end else begin
            shift_next = in_data;
            lz_next    = '0;
            state_next = NORM;
          end
        end
      end
      NORM: begin
        // A nonzero operand always reaches the MSB by lz = IN_BIT-1, so lz never wraps.
        if (shift_reg[IN_BIT-1]) begin
          data_next  = {LZ_W'(IN_BIT - 1) - lz_reg, shift_reg[IN_BIT-2 -: FRAC_BIT]};
          zero_next  = 1'b0;
          state_next = DONE;
        end else begin
          shift_next = shift_reg << 1;
          lz_next    = lz_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = data_reg;
  assign out_zero  = zero_reg;

endmodule
